// File: rtl/resp_frame_pkg.sv
// rtl/resp_frame_pkg.sv - shared types, constants and parity helper for the response frame link
package resp_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DEF_DATA_W = 21;
  // start + data + parity + stop, in bit times
  localparam int FRAME_BITS = DEF_DATA_W + 3;

  // Caller zero-extends narrower words, which leaves the XOR unchanged.
  function automatic logic frame_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/resp_frame_if.sv
// rtl/resp_frame_if.sv - valid/ready word handshake between a producer and the frame transmitter
interface resp_frame_if #(
  parameter int DATA_W = 21
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/resp_bit_timer.sv
// rtl/resp_bit_timer.sv - clocks-per-bit counter, shared by the transmitter and the matching receiver
module resp_bit_timer #(
  parameter int DIV   = 4,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = en && (cnt_q == LAST_CNT);
  assign count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/resp_frame_tx.sv
// rtl/resp_frame_tx.sv - serial response-frame transmitter: start, LSB-first data, parity, stop
module resp_frame_tx
  import resp_frame_pkg::*;
#(
  parameter int DATA_W     = 21,
  parameter int DIV        = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  resp_frame_if.slave in_if,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W  = $clog2(DIV);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DONE_CNT = CNT_W'(DIV - 2);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_next;
  logic [BIDX_W-1:0] idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              timer_clr;
  logic              bit_end;
  logic [CNT_W-1:0]  bit_cnt;

  assign in_if.in_ready = (state_q == IDLE);
  assign accept         = in_if.in_valid && (state_q == IDLE);
  assign shift_next     = shift_q >> 1;

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  resp_bit_timer #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (state_q != IDLE),
    .count   (bit_cnt),
    .bit_end (bit_end)
  );

  // tx_d is the line level for the state being entered, so tx_q never lags the FSM.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_d     = par_q;
    tx_d      = tx_q;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = START;
          shift_d   = in_if.in_data;
          par_d     = frame_parity(32'(in_if.in_data), PARITY_ODD != 0);
          idx_d     = '0;
          tx_d      = 1'b0;
          timer_clr = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_next;
            tx_d    = shift_next[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
    // Registered pulse lands on the timer's last count of the stop bit.
    done_d = (state_q == STOP) && (bit_cnt == DONE_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_resp_frame_tx.sv
// tb/tb_resp_frame_tx.sv - directed bench for resp_frame_tx with even and odd parity instances
module tb_resp_frame_tx;

  logic        clk;
  logic        rst_n;
  logic [20:0] in_data;
  logic        in_valid;
  logic        tx_e, busy_e, done_e;
  logic        tx_o, busy_o, done_o;
  int          vectors;
  int          fails;

  resp_frame_if #(.DATA_W(21)) if_e ();
  resp_frame_if #(.DATA_W(21)) if_o ();

  assign if_e.in_data  = in_data;
  assign if_e.in_valid = in_valid;
  assign if_o.in_data  = in_data;
  assign if_o.in_valid = in_valid;

  resp_frame_tx #(.DATA_W(21), .DIV(4), .PARITY_ODD(0)) dut_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if_e.slave),
    .tx         (tx_e),
    .busy       (busy_e),
    .frame_done (done_e)
  );

  resp_frame_tx #(.DATA_W(21), .DIV(4), .PARITY_ODD(1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if_o.slave),
    .tx         (tx_o),
    .busy       (busy_o),
    .frame_done (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " tx_e"}, 32'(tx_e), 32'd1);
    chk({tag, " busy_e"}, 32'(busy_e), 32'd0);
    chk({tag, " ready_e"}, 32'(if_e.in_ready), 32'd1);
    chk({tag, " done_e"}, 32'(done_e), 32'd0);
    chk({tag, " tx_o"}, 32'(tx_o), 32'd1);
    chk({tag, " busy_o"}, 32'(busy_o), 32'd0);
  endtask

  // Caller has in_valid/in_data set up so the next rising edge is the accept edge.
  task automatic run_frame(input string tag, input logic [20:0] w, input logic pe, input logic po,
                           input logic nv, input logic [20:0] nd, input logic stall);
    logic [20:0] rx_e, rx_o;
    logic        rpe, rpo;
    logic        exp_e, exp_o;
    int          b;
    rx_e = '0;
    rx_o = '0;
    rpe  = 1'bx;
    rpo  = 1'bx;
    @(posedge clk);
    #1;
    in_valid = nv;
    in_data  = nd;
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      b = (c - 1) / 4;
      if (b == 0) begin
        exp_e = 1'b0; exp_o = 1'b0;
      end else if (b <= 21) begin
        exp_e = w[b-1]; exp_o = w[b-1];
      end else if (b == 22) begin
        exp_e = pe; exp_o = po;
      end else begin
        exp_e = 1'b1; exp_o = 1'b1;
      end
      chk($sformatf("%s tx_e c%0d", tag, c), 32'(tx_e), 32'(exp_e));
      chk($sformatf("%s tx_o c%0d", tag, c), 32'(tx_o), 32'(exp_o));
      chk($sformatf("%s done c%0d", tag, c), 32'(done_e), 32'(c == 96));
      chk($sformatf("%s done_o c%0d", tag, c), 32'(done_o), 32'(c == 96));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy_e), 32'd1);
      chk($sformatf("%s ready c%0d", tag, c), 32'(if_e.in_ready), 32'd0);
      if ((c - 1) % 4 == 2) begin
        if (b >= 1 && b <= 21) begin
          rx_e[b-1] = tx_e;
          rx_o[b-1] = tx_o;
        end else if (b == 22) begin
          rpe = tx_e;
          rpo = tx_o;
        end
      end
      if (stall && c >= 20 && c < 28) begin
        in_valid = c[0];
        in_data  = 21'($urandom);
      end
      if (stall && c == 28) in_valid = 1'b0;
    end
    chk({tag, " rx word even"}, 32'(rx_e), 32'(w));
    chk({tag, " rx word odd"}, 32'(rx_o), 32'(w));
    chk({tag, " rx parity even"}, 32'(rpe), 32'(pe));
    chk({tag, " rx parity odd"}, 32'(rpo), 32'(po));
    @(negedge clk);
    check_idle({tag, " post"});
  endtask

  initial begin
    vectors  = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_idle("idle");
    end

    in_data = 21'h000001; in_valid = 1'b1;
    run_frame("single", 21'h000001, 1'b1, 1'b0, 1'b0, 21'h0, 1'b0);

    in_data = 21'h1FFFFF; in_valid = 1'b1;
    run_frame("ones", 21'h1FFFFF, 1'b1, 1'b0, 1'b0, 21'h0, 1'b0);

    in_data = 21'h000000; in_valid = 1'b1;
    run_frame("zero", 21'h000000, 1'b0, 1'b1, 1'b0, 21'h0, 1'b0);

    in_data = 21'h155555; in_valid = 1'b1;
    run_frame("b2b_a", 21'h155555, 1'b1, 1'b0, 1'b1, 21'h0AAAAA, 1'b0);
    run_frame("b2b_b", 21'h0AAAAA, 1'b0, 1'b1, 1'b0, 21'h0, 1'b0);

    in_data = 21'h012345; in_valid = 1'b1;
    run_frame("stall", 21'h012345, 1'b1, 1'b0, 1'b0, 21'h012345, 1'b1);
    repeat (10) begin
      @(negedge clk);
      check_idle("after_stall");
    end

    // bit 10 of this word is 0, so the line is low when reset hits
    in_data = 21'h1FFBFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (45) @(negedge clk);
    chk("pre_reset tx", 32'(tx_e), 32'd0);
    chk("pre_reset busy", 32'(busy_e), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_idle("post_reset");
    end

    in_data = 21'h0F0F0F; in_valid = 1'b1;
    run_frame("recover", 21'h0F0F0F, 1'b0, 1'b1, 1'b0, 21'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/resp_frame_tx.md
# resp_frame_tx

Serial response-frame transmitter. It accepts one parallel response word from the benchmark logic cores, e.g. a 21-bit control-response vector, over a valid/ready handshake. It shifts the word out LSB-first on a single line as an asynchronous-style frame: start bit, data bits, parity, stop. It is the transmitting end of the serial vector link whose receiver deserializes stimulus words for the cores.

## Interface
Parameters:
- DATA_W, 21, width of the response word (1..32)
- DIV, 4, clock cycles per serial bit (2..255)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- clk  in  1  single clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_data  in  DATA_W  response word, sampled on handshake
- in_valid  in  1  producer has a word
- in_ready  out  1  transmitter can accept a word
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on last cycle of stop bit

## Operation
- Handshake: a word is accepted on a rising edge with in_valid & in_ready.
  - in_ready = 1 only in IDLE, combinational from state.
  - in_data is ignored at all other times. Producer must hold in_data stable while in_valid is high and in_ready is low.
- On accept, latch in_data into shift register and parity into a parity flag.
  - Even mode: parity = XOR of data bits.
  - Odd mode: parity = inverted XOR.
- States:
  - IDLE: tx=1, busy=0. On accept go to START.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: tx = shift_reg[0] for DIV cycles per bit, then shift right. Bit index 0..DATA_W-1. After bit DATA_W-1 go to PARITY.
  - PARITY: tx = parity flag for DIV cycles, then go to STOP.
  - STOP: tx=1 for DIV cycles. frame_done=1 on the final cycle. Then go to IDLE.
- Bit timer:
  - Counter 0..DIV-1, cleared on accept and on every bit boundary.
  - A bit ends when counter == DIV-1.
- Bit index counter is ceil(log2(DATA_W)) bits wide and must not wrap inside DATA.
- busy = 1 in START, DATA, PARITY and STOP.
- tx is registered, so it has no glitches.

## Timing
- Reset values, applied immediately by async reset:
  - state = IDLE, tx=1, busy=0, frame_done=0, in_ready=1
  - shift register, parity flag and counters = 0
- Reset mid-frame aborts the frame: tx returns high at once and nothing is resumed after reset release.
- Latency: accept at edge k, so tx=0 (start bit) from edge k to edge k+DIV.
- Frame length is (DATA_W+3)*DIV cycles from edge k to the return to IDLE. With the defaults this is 96 cycles.
- Back-to-back: in_ready rises in the cycle after frame_done. With in_valid held high, the next word is accepted on that edge.
  - Minimum line-high gap between frames = stop bit (DIV cycles) + 1 idle cycle.
- in_valid dropping before acceptance is legal, and no word is taken.
- in_valid high during a frame has no effect until IDLE.

## Structure
- Package resp_frame_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP
  - the localparam FRAME_BITS = DATA_W+3
  - the function frame_parity(data, odd)
- One sub-module, resp_bit_timer: the DIV counter with clear input and bit_end output. It is reusable by the matching receiver.
- Top level holds the FSM, shift register, bit index and parity flag.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, release, in_valid=0 for 20 cycles.
  - Required: tx=1, busy=0, in_ready=1 and frame_done=0 throughout.
- Single frame, DATA_W=21, DIV=4, even parity, in_data=21'h000001:
  - tx low cycles 1-4, then high 5-8 (bit 0).
  - Low 9-88 (bits 1..20), then parity high 89-92, stop high 93-96.
  - frame_done=1 only in cycle 96.
- Parity modes, in_data=21'h1FFFFF (21 ones):
  - Even mode: parity bit = 1.
  - Odd mode: parity bit = 0.
  - in_data=0 gives parity 0 in even mode and 1 in odd mode.
- Back-to-back, in_valid held high with words 21'h155555 then 21'h0AAAAA:
  - Second accept occurs exactly 1 cycle after frame_done.
  - The receiver model decodes both words bit-exact.
  - in_ready stays low for the whole of each frame.
- Reset mid-frame:
  - Stimulus: assert rst_n low during DATA bit 10.
  - Required: tx=1 and busy=0 in the same cycle, asynchronously.
  - After release there is no further line activity until a new handshake, and the next frame is correct.
- Handshake stall: pulse in_valid during a frame with changing in_data. Required: it is ignored and the current frame stays uncorrupted.
